// File: rtl/prio_encoder8_3_hs.sv
// Sequential 8-to-3 priority encoder with a valid/ready output handshake.
// Request pulses collect in a pending register and are emitted one index per accepted transfer.
module prio_encoder8_3_hs #(
  parameter int N         = 8,
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  input  logic         ovr_clr,
  output logic [2:0]   code,
  output logic         out_valid,
  output logic [N-1:0] pend,
  output logic [3:0]   pend_cnt,
  output logic         overrun
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [2:0]   code_q, code_d;
  logic [N-1:0] pend_q, pend_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         ovr_q, ovr_d;

  logic [2:0]   sel;
  logic         sel_found;
  logic [N-1:0] grant;
  logic         load;

  assign code      = code_q;
  assign out_valid = (state_q == HOLD);
  assign pend      = pend_q;
  assign pend_cnt  = cnt_q;
  assign overrun   = ovr_q;

  assign load = (state_q == EMPTY) | (out_valid & out_ready);

  // Scan so that the last set bit visited is the highest-priority one.
  always_comb begin
    int unsigned j;
    sel       = 3'd0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      j = PRIO_HIGH ? i : (7 - i);
      if (pend_q[j[2:0]]) begin
        sel       = j[2:0];
        sel_found = 1'b1;
      end
    end
  end

  assign grant = (load && sel_found) ? (N'(1) << sel) : '0;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pend_d  = pend_q | req;
    if (load) begin
      if (sel_found) begin
        code_d  = sel;
        state_d = HOLD;
        pend_d  = (pend_q & ~grant) | req;
      end else begin
        state_d = EMPTY;
        pend_d  = req;
      end
    end
    // A new set condition takes precedence over a same-cycle clear.
    ovr_d = (|(req & pend_q & ~grant)) | (ovr_q & ~ovr_clr);
    cnt_d = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt_d = cnt_d + 4'(pend_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      code_q  <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_prio_encoder8_3_hs.sv
// Bench for prio_encoder8_3_hs: both priority orders driven in parallel and
// compared each cycle against a set-based reference model.
module tb_prio_encoder8_3_hs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       out_ready = 1'b0;
  logic       ovr_clr = 1'b0;

  logic [2:0] code_h, code_l;
  logic       valid_h, valid_l;
  logic [7:0] pend_h, pend_l;
  logic [3:0] cnt_h, cnt_l;
  logic       ovr_h, ovr_l;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prio_encoder8_3_hs #(.N(8), .PRIO_HIGH(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready), .ovr_clr(ovr_clr),
    .code(code_h), .out_valid(valid_h), .pend(pend_h), .pend_cnt(cnt_h), .overrun(ovr_h)
  );

  prio_encoder8_3_hs #(.N(8), .PRIO_HIGH(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready), .ovr_clr(ovr_clr),
    .code(code_l), .out_valid(valid_l), .pend(pend_l), .pend_cnt(cnt_l), .overrun(ovr_l)
  );

  // Reference model: index 0 = PRIO_HIGH=1 instance, index 1 = PRIO_HIGH=0 instance.
  bit m_pend[2][8];
  bit m_valid[2];
  int m_code[2];
  bit m_ovr[2];

  function automatic int pick(input int k, input bit p[8]);
    int r = -1;
    for (int n = 0; n < 8; n++) begin
      int idx = (k == 0) ? 7 - n : n;
      if (r < 0 && p[idx]) r = idx;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_pend[k][i] = 0;
      m_valid[k] = 0;
      m_code[k]  = 0;
      m_ovr[k]   = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit load = !m_valid[k] || out_ready;
      int g = load ? pick(k, m_pend[k]) : -1;
      bit hit = 0;
      for (int i = 0; i < 8; i++)
        if (req[i] && m_pend[k][i] && i != g) hit = 1;
      m_ovr[k] = hit ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr[k]);
      if (load) begin
        if (g >= 0) begin
          m_code[k]    = g;
          m_valid[k]   = 1;
          m_pend[k][g] = 0;
        end else begin
          m_valid[k] = 0;
        end
      end
      for (int i = 0; i < 8; i++) if (req[i]) m_pend[k][i] = 1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int pv = 0;
      int pc = 0;
      for (int i = 7; i >= 0; i--) begin
        pv = pv * 2 + int'(m_pend[k][i]);
        pc += int'(m_pend[k][i]);
      end
      if (k == 0) begin
        chk("valid_h", int'(valid_h), int'(m_valid[0]));
        chk("pend_h", int'(pend_h), pv);
        chk("cnt_h", int'(cnt_h), pc);
        chk("ovr_h", int'(ovr_h), int'(m_ovr[0]));
        if (m_valid[0]) chk("code_h", int'(code_h), m_code[0]);
      end else begin
        chk("valid_l", int'(valid_l), int'(m_valid[1]));
        chk("pend_l", int'(pend_l), pv);
        chk("cnt_l", int'(cnt_l), pc);
        chk("ovr_l", int'(ovr_l), int'(m_ovr[1]));
        if (m_valid[1]) chk("code_l", int'(code_l), m_code[1]);
      end
    end
  endtask

  task automatic step(input logic [7:0] r, input logic rdy, input logic clr);
    req = r;
    out_ready = rdy;
    ovr_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    #1 check_all();
    chk("rst_code_h", int'(code_h), 0);
    chk("rst_code_l", int'(code_l), 0);

    for (int n = 0; n < 5; n++) step(8'h00, 1'b1, 1'b0);

    // 7,4,2 on the high-priority instance, 2,4,7 on the other.
    step(8'b1001_0100, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    chk("seq0_h", int'(code_h), 7);
    chk("seq0_l", int'(code_l), 2);
    step(8'h00, 1'b1, 1'b0);
    chk("seq1_h", int'(code_h), 4);
    step(8'h00, 1'b1, 1'b0);
    chk("seq2_h", int'(code_h), 2);
    chk("seq2_l", int'(code_l), 7);
    step(8'h00, 1'b1, 1'b0);
    chk("seq_end", int'(valid_h), 0);

    // Hold with out_ready low, then overrun and clear.
    step(8'h08, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      step(8'h00, 1'b0, 1'b0);
      chk("hold_code", int'(code_h), 3);
    end
    step(8'h08, 1'b0, 1'b0);
    step(8'h08, 1'b0, 1'b0);
    chk("ovr_set", int'(ovr_h), 1);
    step(8'h08, 1'b0, 1'b1);
    chk("ovr_set_wins", int'(ovr_h), 1);
    step(8'h00, 1'b0, 1'b1);
    chk("ovr_clr", int'(ovr_h), 0);
    for (int n = 0; n < 3; n++) step(8'h00, 1'b1, 1'b0);

    // Re-request on the acceptance edge of code 5.
    step(8'h20, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h20, 1'b1, 1'b0);
    chk("rereq_pend", int'(pend_h), 8'h20);
    step(8'h00, 1'b1, 1'b0);
    chk("rereq_code", int'(code_h), 5);
    chk("rereq_ovr", int'(ovr_h), 0);
    step(8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with everything pending.
    step(8'hFF, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    chk("arst_code_h", int'(code_h), 0);
    chk("arst_code_l", int'(code_l), 0);
    req = 8'h01;
    #2 rst_n = 1'b1;
    step(8'h01, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    chk("post_rst_code", int'(code_h), 0);
    chk("post_rst_valid", int'(valid_h), 1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
